// File: rtl/x_evt16_collect.sv
// 16-channel sticky event collector with masked OR fold and IRQ request/ack FSM.
// Optional build macro X_EVT16_EDGE_EN selects rising-edge capture instead of level capture.
module x_evt16_collect #(
    parameter int unsigned MIN_PULSE = 4,
    parameter int unsigned HOLDOFF   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] EVT,
    input  logic [15:0] MASK,
    input  logic        CLR_EN,
    input  logic [15:0] CLR,
    input  logic        ACK,
    output logic [15:0] PEND,
    output logic [15:0] ACT,
    output logic [3:0]  FIRST,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] PULSE_LOAD   = 8'(MIN_PULSE - 1);
    localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ack_lat_q, ack_lat_d;
    logic        irq_q, irq_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] cap;
    logic        any;

`ifdef X_EVT16_EDGE_EN
    logic [15:0] evt_q, evt_d;

    always_comb begin
        evt_d = EVT;
    end

    // Reset value of 0 makes a level held through reset release count as one edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign cap = EVT & ~evt_q;
`else
    assign cap = EVT;
`endif

    // Capture is OR'd in after the clear so a same-cycle set beats the clear.
    always_comb begin
        pend_d = (pend_q & ~({16{CLR_EN}} & CLR)) | cap;
    end

    assign any = |ACT;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ack_lat_q <= 1'b0;
            irq_q     <= 1'b0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_lat_q <= ack_lat_d;
            irq_q     <= irq_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ack_lat_d = ack_lat_q;
        irq_d     = irq_q;
        unique case (state_q)
            S_IDLE: begin
                irq_d = 1'b0;
                if (any) begin
                    state_d = S_REQ;
                    irq_d   = 1'b1;
                    cnt_d   = PULSE_LOAD;
                end
            end
            S_REQ: begin
                irq_d = 1'b1;
                if ((cnt_q == 8'd0) && (ack_lat_q || ACK)) begin
                    state_d   = S_WAIT;
                    irq_d     = 1'b0;
                    cnt_d     = HOLDOFF_LOAD;
                    ack_lat_d = 1'b0;
                end else begin
                    ack_lat_d = ack_lat_q | ACK;
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            S_WAIT: begin
                irq_d = 1'b0;
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                irq_d     = 1'b0;
                cnt_d     = '0;
                ack_lat_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        PEND  = pend_q;
        ACT   = pend_q & ~MASK;
        IRQ   = irq_q;
        FIRST = 4'd0;
        // Scan high to low so the lowest set bit is written last and wins.
        for (int i = 15; i >= 0; i--) begin
            if (ACT[i]) begin
                FIRST = 4'(i);
            end
        end
    end

endmodule

// File: tb/tb_x_evt16_collect.sv
// Directed bench for x_evt16_collect: a row table drives one cycle each, expectations
// are queued per cycle and checked by an independent monitor on the falling edge.
module tb_x_evt16_collect;

    logic        CLK;
    logic        RST;
    logic [15:0] EVT;
    logic [15:0] MASK;
    logic        CLR_EN;
    logic [15:0] CLR;
    logic        ACK;
    logic [15:0] PEND;
    logic [15:0] ACT;
    logic [3:0]  FIRST;
    logic        IRQ;

    x_evt16_collect #(
        .MIN_PULSE (4),
        .HOLDOFF   (2)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EVT    (EVT),
        .MASK   (MASK),
        .CLR_EN (CLR_EN),
        .CLR    (CLR),
        .ACK    (ACK),
        .PEND   (PEND),
        .ACT    (ACT),
        .FIRST  (FIRST),
        .IRQ    (IRQ)
    );

    typedef struct {
        logic        rst;
        logic [15:0] evt;
        logic [15:0] mask;
        logic        clr_en;
        logic [15:0] clr;
        logic        ack;
        logic [15:0] pend;
        logic [15:0] act;
        logic [3:0]  first;
        logic        irq;
    } row_t;

    typedef struct {
        int          cyc;
        int          row;
        logic [15:0] pend;
        logic [15:0] act;
        logic [3:0]  first;
        logic        irq;
    } exp_t;

    row_t rows[$];
    exp_t sb[$];
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    task automatic add(input logic rst, input logic [15:0] evt, input logic [15:0] mask,
                       input logic clr_en, input logic [15:0] clr, input logic ack,
                       input logic [15:0] pend, input logic [15:0] act,
                       input logic [3:0] first, input logic irq);
        row_t r;
        r.rst = rst; r.evt = evt; r.mask = mask; r.clr_en = clr_en; r.clr = clr; r.ack = ack;
        r.pend = pend; r.act = act; r.first = first; r.irq = irq;
        rows.push_back(r);
    endtask

    // Monitor: compares whatever expectations are due in the current cycle.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc_cnt || PEND !== e.pend || ACT !== e.act ||
                FIRST !== e.first || IRQ !== e.irq) begin
                n_fails++;
                $display("FAIL row%0d: got PEND=%h ACT=%h FIRST=%0d IRQ=%b, want PEND=%h ACT=%h FIRST=%0d IRQ=%b",
                         e.row, PEND, ACT, FIRST, IRQ, e.pend, e.act, e.first, e.irq);
            end
        end
    end

    initial begin
        logic [15:0] p7;
        logic [15:0] a7;
        logic [3:0]  f7;
        RST = 1'b1; EVT = '0; MASK = '0; CLR_EN = 1'b0; CLR = '0; ACK = 1'b0;

        //   rst evt       mask      ce   clr       ack  pend      act       first irq
        add(1, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0); // 0 reset
        add(0, 16'h0010, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0); // 1 pulse
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0010, 4, 0); // 2 captured
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'h0010, 4, 1); // 3 IRQ rises, ack
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0010, 4, 1); // 4
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0010, 4, 1); // 5
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0010, 4, 1); // 6 last high
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0010, 4, 0); // 7 low gap
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0010, 4, 0); // 8
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0010, 4, 0); // 9
        add(0, 16'h0000, 16'h0000, 1, 16'h0010, 0, 16'h0010, 16'h0010, 4, 1); // 10 re-request, clear
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1); // 11 IRQ held w/o ack
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1); // 12
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1); // 13
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 1); // 14 late ack
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0); // 15 wait
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0); // 16 ack in wait
        add(0, 16'h0012, 16'h0012, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0); // 17 masked pulse
        add(0, 16'h0000, 16'h0012, 0, 16'h0000, 0, 16'h0012, 16'h0000, 0, 0); // 18
        add(0, 16'h0000, 16'h0012, 0, 16'h0000, 0, 16'h0012, 16'h0000, 0, 0); // 19
        add(0, 16'h0000, 16'h0012, 0, 16'h0000, 0, 16'h0012, 16'h0000, 0, 0); // 20 IRQ stays 0
        add(0, 16'h0000, 16'h0002, 0, 16'h0000, 0, 16'h0012, 16'h0010, 4, 0); // 21 unmask same cycle
        add(0, 16'h0001, 16'h0002, 1, 16'h0003, 0, 16'h0012, 16'h0010, 4, 1); // 22 clear race
        add(0, 16'h0000, 16'h0002, 0, 16'h0000, 0, 16'h0011, 16'h0011, 0, 1); // 23 set wins
        add(0, 16'h0000, 16'h0001, 0, 16'h0000, 0, 16'h0011, 16'h0010, 4, 1); // 24
        add(1, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0); // 25 async reset
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0); // 26
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0); // 27 events lost
        add(0, 16'h0080, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0); // 28 EVT[7] rises
        add(0, 16'h0080, 16'h0000, 0, 16'h0000, 0, 16'h0080, 16'h0080, 7, 0); // 29
        add(0, 16'h0080, 16'h0000, 1, 16'h0080, 0, 16'h0080, 16'h0080, 7, 1); // 30 clear bit 7
        // Rows 31..39 depend on capture mode; PEND fields patched below.
        for (int r = 31; r <= 39; r++) begin
            add(0, (r <= 37) ? 16'h0080 : ((r == 39) ? 16'h0080 : 16'h0000),
                16'h0000, 0, 16'h0000, 0, 16'h0080, 16'h0080, 7, 1);
        end
        add(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0080, 16'h0080, 7, 1); // 40 re-captured

`ifdef X_EVT16_EDGE_EN
        p7 = 16'h0000; a7 = 16'h0000; f7 = 4'd0;
`else
        p7 = 16'h0080; a7 = 16'h0080; f7 = 4'd7;
`endif
        for (int r = 31; r <= 39; r++) begin
            rows[r].pend = p7; rows[r].act = a7; rows[r].first = f7;
        end

        for (int r = 0; r < rows.size(); r++) begin
            exp_t e;
            @(posedge CLK);
            #1;
            RST = rows[r].rst; EVT = rows[r].evt; MASK = rows[r].mask;
            CLR_EN = rows[r].clr_en; CLR = rows[r].clr; ACK = rows[r].ack;
            e.cyc = cyc_cnt; e.row = r;
            e.pend = rows[r].pend; e.act = rows[r].act;
            e.first = rows[r].first; e.irq = rows[r].irq;
            sb.push_back(e);
        end

        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
